// File: rtl/hpi_target_responder.sv
// rtl/hpi_target_responder.sv - HPI target responder: word RAM via DATA/ADDRESS, mailbox and STATUS
module hpi_target_responder #(
    parameter int AW       = 12,
    parameter int READ_LAT = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  hpi_address,
    input  logic        hpi_cs_n,
    input  logic        hpi_r_n,
    input  logic        hpi_w_n,
    input  logic [15:0] hpi_data_in,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    output logic        hpi_int,
    output logic [15:0] mbx_data,
    output logic        mbx_valid,
    input  logic        mbx_ack,
    input  logic [15:0] reply_data,
    input  logic        reply_we,
    output logic        proto_err
);

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_MAILBOX = 2'd1;
    localparam logic [1:0] REG_ADDRESS = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam logic [AW:0] ADDR_STEP = (AW+1)'(2);
    localparam logic [2:0]  CNT_INIT  = 3'(READ_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_EXEC,
        RD_WAIT,
        RD_DRIVE,
        WAIT_REL
    } state_t;

    state_t      state;
    logic [1:0]  addr_q;
    logic        cs_n_q;
    logic        r_n_q;
    logic        w_n_q;
    logic [15:0] din_q;
    logic        act_prev;
    logic        ill_prev;
    logic [1:0]  sel;
    logic [15:0] wr_data;
    logic [2:0]  cnt;
    logic [AW:0] addr_reg;
    logic [15:0] rd_val;
    logic [15:0] ram_q;
    logic [15:0] reply_reg;
    logic        reply_pending;

    logic [15:0] ram [0:(2**AW)-1];

    logic act;
    logic illegal;
    logic start;
    logic rd_fetch;
    logic [AW-1:0] word_idx;

    // Every decision below is taken on the registered copies of the bus pins.
    assign act      = !cs_n_q && ((!r_n_q) ^ (!w_n_q));
    assign illegal  = !cs_n_q && !r_n_q && !w_n_q;
    assign start    = act && !act_prev;
    assign rd_fetch = (state == IDLE) && start && !r_n_q && (addr_q == REG_DATA);
    assign word_idx = addr_reg[AW:1];
    assign hpi_int  = mbx_valid;

    always_ff @(posedge Clk) begin
        if ((state == WR_EXEC) && (sel == REG_DATA))
            ram[word_idx] <= wr_data;
        if (rd_fetch)
            ram_q <= ram[word_idx];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            addr_q        <= 2'd0;
            cs_n_q        <= 1'b1;
            r_n_q         <= 1'b1;
            w_n_q         <= 1'b1;
            din_q         <= 16'd0;
            act_prev      <= 1'b0;
            ill_prev      <= 1'b0;
            sel           <= REG_DATA;
            wr_data       <= 16'd0;
            cnt           <= 3'd0;
            addr_reg      <= '0;
            rd_val        <= 16'd0;
            hpi_data_out  <= 16'd0;
            hpi_data_oe   <= 1'b0;
            mbx_data      <= 16'd0;
            mbx_valid     <= 1'b0;
            reply_reg     <= 16'd0;
            reply_pending <= 1'b0;
            proto_err     <= 1'b0;
        end else begin
            addr_q    <= hpi_address;
            cs_n_q    <= hpi_cs_n;
            r_n_q     <= hpi_r_n;
            w_n_q     <= hpi_w_n;
            din_q     <= hpi_data_in;
            act_prev  <= act;
            ill_prev  <= illegal;
            proto_err <= 1'b0;

            if (mbx_ack)
                mbx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        sel     <= addr_q;
                        wr_data <= din_q;
                        if (!r_n_q) begin
                            state <= RD_WAIT;
                            cnt   <= CNT_INIT;
                            // Read side effects are committed at fetch so an early release still applies them.
                            case (addr_q)
                                REG_DATA: begin
                                    addr_reg <= addr_reg + ADDR_STEP;
                                    rd_val   <= 16'd0;
                                end
                                REG_MAILBOX: begin
                                    rd_val        <= reply_reg;
                                    reply_pending <= 1'b0;
                                end
                                REG_ADDRESS: rd_val <= 16'(addr_reg);
                                default:     rd_val <= {14'd0, reply_pending, mbx_valid};
                            endcase
                        end else begin
                            state <= WR_EXEC;
                        end
                    end else if (illegal && !ill_prev) begin
                        proto_err <= 1'b1;
                    end
                end
                WR_EXEC: begin
                    case (sel)
                        REG_DATA:    addr_reg <= addr_reg + ADDR_STEP;
                        REG_MAILBOX: begin
                            mbx_data  <= wr_data;
                            mbx_valid <= 1'b1;
                        end
                        REG_ADDRESS: addr_reg <= {wr_data[AW:1], 1'b0};
                        default:     ;
                    endcase
                    state <= WAIT_REL;
                end
                RD_WAIT: begin
                    if (cnt == 3'd0) begin
                        if (act) begin
                            state        <= RD_DRIVE;
                            hpi_data_oe  <= 1'b1;
                            hpi_data_out <= (sel == REG_DATA) ? ram_q : rd_val;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RD_DRIVE: begin
                    if (!act) begin
                        state        <= IDLE;
                        hpi_data_oe  <= 1'b0;
                        hpi_data_out <= 16'd0;
                    end
                end
                WAIT_REL: begin
                    if (!act)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A local reply load in the same cycle as a mailbox read keeps the reply pending.
            if (reply_we) begin
                reply_reg     <= reply_data;
                reply_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hpi_target_responder.sv
// tb/tb_hpi_target_responder.sv - randomized and directed bench for hpi_target_responder
module tb_hpi_target_responder;

    localparam int AW = 12;
    localparam int RL = 2;
    localparam logic [1:0] A_DATA = 2'd0, A_MBX = 2'd1, A_ADDR = 2'd2, A_STAT = 2'd3;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [1:0]  hpi_address;
    logic        hpi_cs_n, hpi_r_n, hpi_w_n;
    logic [15:0] hpi_data_in;
    logic [15:0] hpi_data_out;
    logic        hpi_data_oe;
    logic        hpi_int;
    logic [15:0] mbx_data;
    logic        mbx_valid;
    logic        mbx_ack;
    logic [15:0] reply_data;
    logic        reply_we;
    logic        proto_err;

    hpi_target_responder #(.AW(AW), .READ_LAT(RL)) dut (
        .Clk(Clk), .Reset(Reset),
        .hpi_address(hpi_address), .hpi_cs_n(hpi_cs_n), .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n),
        .hpi_data_in(hpi_data_in), .hpi_data_out(hpi_data_out), .hpi_data_oe(hpi_data_oe),
        .hpi_int(hpi_int), .mbx_data(mbx_data), .mbx_valid(mbx_valid), .mbx_ack(mbx_ack),
        .reply_data(reply_data), .reply_we(reply_we), .proto_err(proto_err)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int passed = 0;
    int fails = 0;

    // Reference model: byte address, word memory with known-flags, mailbox/reply state.
    logic [15:0] mem [0:(2**AW)-1];
    bit          mknown [0:(2**AW)-1];
    int          maddr;
    logic [15:0] m_mbx, m_reply;
    bit          m_mvalid, m_pending;

    logic [15:0] rd_data, rd_exp;
    bit          rd_known, rd_stable;
    int          rd_lat;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        maddr = 0; m_mbx = 16'd0; m_reply = 16'd0; m_mvalid = 0; m_pending = 0;
    endfunction

    function automatic void m_write(input logic [1:0] a, input logic [15:0] d);
        case (a)
            A_DATA: begin
                mem[maddr / 2] = d; mknown[maddr / 2] = 1;
                maddr = (maddr + 2) % (2 ** (AW + 1));
            end
            A_MBX:  begin m_mbx = d; m_mvalid = 1; end
            A_ADDR: maddr = int'(d) % (2 ** (AW + 1)) / 2 * 2;
            default: ;
        endcase
    endfunction

    function automatic void m_read(input logic [1:0] a, output logic [15:0] e, output bit k);
        k = 1;
        case (a)
            A_DATA: begin
                k = mknown[maddr / 2]; e = mem[maddr / 2];
                maddr = (maddr + 2) % (2 ** (AW + 1));
            end
            A_MBX:  begin e = m_reply; m_pending = 0; end
            A_ADDR: e = 16'(maddr);
            default: e = {14'd0, m_pending, m_mvalid};
        endcase
    endfunction

    // All bus tasks start and end on a falling edge with the bus idle.
    task automatic wr(input logic [1:0] a, input logic [15:0] d, input bit ack_exec);
        hpi_address = a; hpi_data_in = d; hpi_cs_n = 0; hpi_w_n = 0;
        repeat (2) @(negedge Clk);
        if (ack_exec) mbx_ack = 1;
        @(negedge Clk);
        mbx_ack = 0; hpi_cs_n = 1; hpi_w_n = 1;
        repeat (3) @(negedge Clk);
        if (ack_exec) m_mvalid = 0;
        m_write(a, d);
    endtask

    task automatic rd(input logic [1:0] a, input int hold);
        hpi_address = a; hpi_cs_n = 0; hpi_r_n = 0;
        rd_lat = -1; rd_stable = 1; rd_data = 16'hxxxx;
        for (int i = 1; i <= hold; i++) begin
            @(posedge Clk); #1;
            if (rd_lat >= 0 && (hpi_data_oe !== 1'b1 || hpi_data_out !== rd_data)) rd_stable = 0;
            if (rd_lat < 0 && hpi_data_oe === 1'b1) begin
                rd_lat = i - 1; rd_data = hpi_data_out;
            end
        end
        @(negedge Clk);
        hpi_cs_n = 1; hpi_r_n = 1;
        repeat (3) @(negedge Clk);
        if (rd_lat < 0) chk("rd_timeout_oe", 16'(hpi_data_oe), 16'd1);
        chk("rd_release_oe", {hpi_data_out[14:0], hpi_data_oe}, 16'd0);
        m_read(a, rd_exp, rd_known);
    endtask

    task automatic chk_mbx(input string tag);
        chk({tag, "_valid"}, {14'd0, hpi_int, mbx_valid}, {14'd0, m_mvalid, m_mvalid});
        chk({tag, "_data"}, mbx_data, m_mbx);
    endtask

    int pulses;
    logic [1:0] ra;
    logic [15:0] rdat;

    initial begin
        Reset = 1; hpi_address = 0; hpi_cs_n = 1; hpi_r_n = 1; hpi_w_n = 1;
        hpi_data_in = 0; mbx_ack = 0; reply_data = 0; reply_we = 0;
        for (int i = 0; i < 2 ** AW; i++) mknown[i] = 0;
        m_reset();
        repeat (3) @(negedge Clk);
        chk("rst_data_out", hpi_data_out, 16'd0);
        chk("rst_flags", {11'd0, hpi_data_oe, hpi_int, mbx_valid, proto_err, 1'b0}, 16'd0);
        chk("rst_mbx_data", mbx_data, 16'd0);
        Reset = 0;
        repeat (2) @(negedge Clk);

        // Auto-incrementing DATA access
        wr(A_ADDR, 16'h0100, 0);
        wr(A_DATA, 16'hBEEF, 0);
        wr(A_DATA, 16'h1234, 0);
        wr(A_ADDR, 16'h0100, 0);
        rd(A_DATA, 8); chk("seq_rd0", rd_data, 16'hBEEF);
        rd(A_DATA, 8); chk("seq_rd1", rd_data, 16'h1234);
        rd(A_ADDR, 8); chk("seq_addr", rd_data, 16'h0104);
        chk("seq_addr_model", rd_data, rd_exp);

        // Strobe held 20 cycles: latency, stability, single increment
        wr(A_ADDR, 16'h0200, 0);
        rd(A_DATA, 20);
        chk("hold_lat", 16'(rd_lat), 16'(RL + 1));
        chk("hold_stable", 16'(rd_stable), 16'd1);
        rd(A_ADDR, 8); chk("hold_addr", rd_data, 16'h0202);

        // Address wrap at the top of the RAM
        wr(A_ADDR, 16'h1FFE, 0);
        wr(A_DATA, 16'hA5A5, 0);
        rd(A_ADDR, 8); chk("wrap_addr", rd_data, 16'h0000);
        wr(A_ADDR, 16'hFFFF, 0);
        rd(A_ADDR, 8); chk("addr_mask", rd_data, 16'h1FFE);
        rd(A_DATA, 8); chk("wrap_data", rd_data, 16'hA5A5);

        // Mailbox write, ack collision, ack alone
        wr(A_MBX, 16'h0042, 0);
        chk_mbx("mbx1");
        chk("mbx1_int", 16'(hpi_int), 16'd1);
        rd(A_STAT, 8); chk("mbx1_status", rd_data, 16'h0001);
        wr(A_MBX, 16'h0043, 1);
        chk("mbx2_valid", 16'(mbx_valid), 16'd1);
        chk("mbx2_data", mbx_data, 16'h0043);
        mbx_ack = 1; @(negedge Clk); mbx_ack = 0; m_mvalid = 0;
        chk("mbx_ack_clear", {14'd0, hpi_int, mbx_valid}, 16'd0);

        // Reply path
        reply_data = 16'h7777; reply_we = 1; @(negedge Clk); reply_we = 0;
        m_reply = 16'h7777; m_pending = 1;
        rd(A_STAT, 8); chk("reply_status", rd_data, 16'h0002);
        wr(A_STAT, 16'hFFFF, 0);
        rd(A_MBX, 8); chk("reply_read", rd_data, 16'h7777);
        rd(A_STAT, 8); chk("reply_cleared", rd_data, 16'h0000);

        // Illegal strobe: one proto_err pulse, nothing else moves
        pulses = 0;
        hpi_address = A_MBX; hpi_data_in = 16'hDEAD; hpi_cs_n = 0; hpi_r_n = 0; hpi_w_n = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk); #1;
            if (proto_err === 1'b1) pulses++;
            if (hpi_data_oe !== 1'b0) pulses += 100;
        end
        @(negedge Clk); hpi_cs_n = 1; hpi_r_n = 1; hpi_w_n = 1;
        repeat (3) @(negedge Clk);
        chk("proto_pulses", 16'(pulses), 16'd1);
        chk_mbx("proto_mbx");
        rd(A_ADDR, 8); chk("proto_addr", rd_data, rd_exp);

        // Asynchronous reset while driving
        hpi_address = A_DATA; hpi_cs_n = 0; hpi_r_n = 0;
        for (int i = 0; i < 10 && hpi_data_oe !== 1'b1; i++) begin
            @(posedge Clk); #1;
        end
        chk("rstmid_oe_before", 16'(hpi_data_oe), 16'd1);
        #2 Reset = 1;
        #1 chk("rstmid_async", {hpi_data_out[14:0], hpi_data_oe}, 16'd0);
        hpi_cs_n = 1; hpi_r_n = 1;
        @(negedge Clk); Reset = 0; m_reset();
        repeat (2) @(negedge Clk);
        rd(A_ADDR, 8); chk("rstmid_addr", rd_data, 16'h0000);
        rd(A_STAT, 8); chk("rstmid_status", rd_data, 16'h0000);

        // Randomized traffic against the reference model
        wr(A_ADDR, 16'h0000, 0);
        for (int n = 0; n < 80; n++) begin
            rdat = 16'($urandom_range(0, 65535));
            ra = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0: begin mbx_ack = 1; @(negedge Clk); mbx_ack = 0; m_mvalid = 0; end
                1: begin
                    reply_data = rdat; reply_we = 1; @(negedge Clk); reply_we = 0;
                    m_reply = rdat; m_pending = 1;
                end
                2: wr(A_ADDR, rdat & 16'hE03F, 0);
                3, 4, 5: wr(ra, rdat, ($urandom_range(0, 3) == 0));
                default: begin
                    rd(ra, 6);
                    if (rd_known) chk("rand_rd", rd_data, rd_exp);
                end
            endcase
            chk_mbx("rand_mbx");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
